delay_sweep_sequencer: RTL and testbench
========================================

DELAY_SWEEP_SEQUENCER -- requirements
Module: delay_sweep_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning beamformer channels with a delay register.
REQ-002 SHALL have parameter NUM_BEAMS, default 8, meaning steering-table entries.
REQ-003 SHALL have parameter IDX_W, default 3, meaning delay width, equal to clog2(BUFFER_SIZE).
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ws, input, 1, I2S word-select; the frame tick is its rising edge, sampled on clk.
REQ-007 SHALL have ports cfg_we (1), cfg_beam (clog2 NUM_BEAMS), cfg_ch (2) and cfg_delay (IDX_W), all inputs, forming the table write port.
REQ-008 SHALL have ports sweep_en (1), sweep_last (clog2 NUM_BEAMS) and dwell_frames (8), all inputs, for sweep control.
REQ-009 SHALL have ports load_req (1) and load_beam (clog2 NUM_BEAMS), inputs, for a manual load request.
REQ-010 SHALL have port load_ack, output, 1, a one-cycle pulse when a manual request is accepted.
REQ-011 SHALL have ports dly_sel (3), dly_data (1) and dly_clk (1), outputs, forming the serial delay-register programming bus.
REQ-012 SHALL have ports busy (1), beam_idx (clog2 NUM_BEAMS) and load_done (1), outputs; load_done is a one-cycle pulse.

Function
REQ-013 SHALL store the table as NUM_BEAMS x NUM_CH x IDX_W bits; cfg_we writes entry [cfg_beam][cfg_ch] at the clock edge; writes with cfg_ch >= NUM_CH are ignored.
REQ-014 SHALL implement the FSM states IDLE, SHIFT_LO, SHIFT_HI and DONE.
REQ-015 SHALL, on load start in IDLE, snapshot the selected beam's delays; later table writes do not affect a load in progress.
REQ-016 SHALL shift channels in order 0..NUM_CH-1 and bits MSB first.
REQ-017 SHALL drive each bit in a SHIFT_LO cycle with dly_sel = channel, dly_data = bit and dly_clk = 0.
REQ-018 SHALL follow each SHIFT_LO cycle with a SHIFT_HI cycle in which dly_sel and dly_data are held and dly_clk = 1.
REQ-019 SHALL use NUM_CH*IDX_W bit pairs per load, then one DONE cycle, so a load takes 2*NUM_CH*IDX_W+1 cycles (19 at defaults).
REQ-020 SHALL, in DONE, pulse load_done, update beam_idx to the loaded beam and return to IDLE.
REQ-021 SHALL hold busy = 1 in SHIFT_LO, SHIFT_HI and DONE, and dly_clk = 0 outside SHIFT_HI.
REQ-022 SHALL accept load_req only in IDLE: pulse load_ack in the same cycle the FSM leaves IDLE; load_req is held by the requester until load_ack.
REQ-023 SHALL keep an 8-bit frame counter that increments on each ws rising edge while sweep_en = 1, including edges that arrive while busy.
REQ-024 SHALL treat dwell_frames = 0 as 1.
REQ-025 SHALL, when the frame counter reaches dwell_frames, clear the counter and set a pending sweep advance to beam next = (beam_idx == sweep_last) ? 0 : beam_idx+1.
REQ-026 SHALL compute the advance target from the beam_idx value current when the advance starts.
REQ-027 SHALL start a pending sweep advance at the first IDLE cycle, then clear it.
REQ-028 SHALL give a manual load_req priority over a pending sweep advance in the same IDLE cycle; the sweep advance stays pending.
REQ-029 SHALL keep at most one sweep advance pending; further dwell expiries while pending are dropped.
REQ-030 SHALL, when sweep_en falls, clear the frame counter and pending flag and let an in-progress load complete.
REQ-031 SHALL, when beam_idx > sweep_last, take the next advance to beam 0.

Reset
REQ-032 SHALL, while reset = 1 at a clk edge, set state IDLE, all table entries 0, beam_idx 0, frame counter 0, pending 0, ws history 0, and dly_sel, dly_data, dly_clk, busy, load_ack and load_done all 0.
REQ-033 SHALL let reset abort a load mid-shift; dly_clk is 0 from the next cycle and no load_done is issued.

Verification
REQ-034 SHALL verify a manual load: beam 2 = {ch0 = 5, ch1 = 3, ch2 = 6}, load_req with load_beam = 2 -> load_ack in cycle 0; 9 dly_clk pulses carry bits 101 on sel 0, 011 on sel 1, 110 on sel 2; load_done at cycle 18; beam_idx = 2.
REQ-035 SHALL verify a sweep: sweep_en = 1, dwell_frames = 2, sweep_last = 2, 7 ws rising edges -> loads of beams 1, 2, 0 after edges 2, 4 and 6; no load after edge 7.
REQ-036 SHALL verify a collision: dwell expiry and load_req in the same IDLE cycle -> manual beam loads first; the sweep load starts the cycle after that load's DONE.
REQ-037 SHALL verify a mid-load write: cfg_we to the beam being shifted during SHIFT_HI -> the shifted bits are the old values; the next load uses the new value.
REQ-038 SHALL verify reset mid-load: reset asserted at the 4th SHIFT_HI -> the next cycle has busy = 0 and dly_clk = 0, the table is zeroed, and no load_done is issued.
REQ-039 SHALL verify dwell_frames = 0 with sweep_en = 1 -> one advance per ws rising edge.

Source files
------------

// File: rtl/delay_sweep_sequencer.sv
// Beam-steering delay sequencer: holds a per-beam delay table and serially programs
// channel delay registers on manual request or on a frame-counted sweep advance.
module delay_sweep_sequencer #(
  parameter int NUM_CH    = 3,
  parameter int NUM_BEAMS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ws,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_BEAMS)-1:0] cfg_beam,
  input  logic [1:0]                   cfg_ch,
  input  logic [IDX_W-1:0]             cfg_delay,
  input  logic                         sweep_en,
  input  logic [$clog2(NUM_BEAMS)-1:0] sweep_last,
  input  logic [7:0]                   dwell_frames,
  input  logic                         load_req,
  input  logic [$clog2(NUM_BEAMS)-1:0] load_beam,
  output logic                         load_ack,
  output logic [2:0]                   dly_sel,
  output logic                         dly_data,
  output logic                         dly_clk,
  output logic                         busy,
  output logic [$clog2(NUM_BEAMS)-1:0] beam_idx,
  output logic                         load_done
);

  localparam int BW    = $clog2(NUM_BEAMS);
  localparam int NBITS = NUM_CH * IDX_W;
  localparam int CH_IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W  = $clog2(IDX_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  tbl [NUM_BEAMS][NUM_CH];
  logic              ws_q;
  logic [7:0]        frame_cnt;
  logic              pending;
  logic [BW-1:0]     tgt;
  logic [NBITS-1:0]  snap;
  logic [BC_W-1:0]   bit_cnt;

  logic              ws_rise;
  logic [7:0]        dwell_eff;
  logic              expire;
  logic [BW-1:0]     adv_next;
  logic              start_manual;
  logic              start_adv;
  logic [BW-1:0]     start_beam;
  logic [NBITS-1:0]  start_flat;

  always_comb begin
    ws_rise      = ws & ~ws_q;
    dwell_eff    = (dwell_frames == 8'd0) ? 8'd1 : dwell_frames;
    expire       = sweep_en && ws_rise && (({1'b0, frame_cnt} + 9'd1) >= {1'b0, dwell_eff});
    // beam_idx beyond sweep_last wraps to 0 just like reaching it
    adv_next     = (beam_idx >= sweep_last) ? '0 : beam_idx + BW'(1);
    start_manual = (state == IDLE) && load_req;
    start_adv    = (state == IDLE) && !load_req && pending && sweep_en;
    start_beam   = load_req ? load_beam : adv_next;
    start_flat   = '0;
    // channel 0 occupies the top of the snapshot so shifting left walks ch0..chN, MSB first
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      start_flat[(NUM_CH-1-c)*IDX_W +: IDX_W] = tbl[start_beam][CH_IW'(c)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tbl       <= '{default: '0};
      ws_q      <= 1'b0;
      frame_cnt <= '0;
      pending   <= 1'b0;
      beam_idx  <= '0;
      tgt       <= '0;
      snap      <= '0;
      bit_cnt   <= '0;
      dly_sel   <= '0;
      dly_data  <= 1'b0;
      dly_clk   <= 1'b0;
      busy      <= 1'b0;
      load_ack  <= 1'b0;
      load_done <= 1'b0;
    end else begin
      ws_q      <= ws;
      load_ack  <= 1'b0;
      load_done <= 1'b0;

      if (cfg_we && (int'(cfg_ch) < NUM_CH)) tbl[cfg_beam][cfg_ch] <= cfg_delay;

      if (!sweep_en) begin
        frame_cnt <= '0;
        pending   <= 1'b0;
      end else begin
        if (ws_rise) frame_cnt <= expire ? 8'd0 : frame_cnt + 8'd1;
        if (expire && !pending) pending <= 1'b1;
        if (start_adv) pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_manual || start_adv) begin
            state    <= SHIFT_LO;
            load_ack <= start_manual;
            tgt      <= start_beam;
            snap     <= start_flat;
            dly_sel  <= '0;
            dly_data <= start_flat[NBITS-1];
            bit_cnt  <= BC_W'(IDX_W - 1);
            busy     <= 1'b1;
          end
        end
        SHIFT_LO: begin
          state   <= SHIFT_HI;
          dly_clk <= 1'b1;
        end
        SHIFT_HI: begin
          dly_clk <= 1'b0;
          snap    <= snap << 1;
          if (bit_cnt == '0) begin
            if (dly_sel == 3'(NUM_CH - 1)) begin
              state     <= DONE;
              load_done <= 1'b1;
              beam_idx  <= tgt;
              dly_sel   <= '0;
              dly_data  <= 1'b0;
            end else begin
              state    <= SHIFT_LO;
              dly_sel  <= dly_sel + 3'd1;
              dly_data <= snap[NBITS-2];
              bit_cnt  <= BC_W'(IDX_W - 1);
            end
          end else begin
            state    <= SHIFT_LO;
            dly_data <= snap[NBITS-2];
            bit_cnt  <= bit_cnt - BC_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sweep_sequencer.sv
// Randomized bench for delay_sweep_sequencer against a table/bit-stream reference model.
module tb_delay_sweep_sequencer;
  localparam int NUM_CH = 3, NUM_BEAMS = 8, IDX_W = 3, NP = NUM_CH * IDX_W;

  logic clk = 1'b0;
  logic reset, ws, cfg_we, sweep_en, load_req;
  logic [2:0] cfg_beam, cfg_delay, sweep_last, load_beam;
  logic [1:0] cfg_ch;
  logic [7:0] dwell_frames;
  logic load_ack, dly_data, dly_clk, busy, load_done;
  logic [2:0] dly_sel, beam_idx;

  delay_sweep_sequencer #(.NUM_CH(NUM_CH), .NUM_BEAMS(NUM_BEAMS), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .ws(ws), .cfg_we(cfg_we), .cfg_beam(cfg_beam), .cfg_ch(cfg_ch),
    .cfg_delay(cfg_delay), .sweep_en(sweep_en), .sweep_last(sweep_last), .dwell_frames(dwell_frames),
    .load_req(load_req), .load_beam(load_beam), .load_ack(load_ack), .dly_sel(dly_sel),
    .dly_data(dly_data), .dly_clk(dly_clk), .busy(busy), .beam_idx(beam_idx), .load_done(load_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int mtbl [NUM_BEAMS][NUM_CH];
  logic [3:0] pulse_q [$];
  int done_beam_q [$];
  int done_cyc_q [$];
  int start_cyc_q [$];
  int proto_err = 0;
  logic prev_clk = 1'b0, prev_busy = 1'b0, prev_data = 1'b0;
  logic [2:0] prev_sel = '0;

  // Each dly_clk high cycle must follow a low cycle with identical sel/data, inside a busy load.
  always @(negedge clk) begin
    if (dly_clk === 1'b1) begin
      pulse_q.push_back({dly_sel, dly_data});
      if (prev_clk || !busy || prev_sel !== dly_sel || prev_data !== dly_data) proto_err <= proto_err + 1;
    end
    if (load_done === 1'b1) begin
      done_beam_q.push_back(int'(beam_idx));
      done_cyc_q.push_back(cyc);
    end
    if (busy === 1'b1 && !prev_busy) start_cyc_q.push_back(cyc);
    prev_clk  <= (dly_clk === 1'b1);
    prev_busy <= (busy === 1'b1);
    prev_sel  <= dly_sel;
    prev_data <= dly_data;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    pulse_q.delete(); done_beam_q.delete(); done_cyc_q.delete(); start_cyc_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; ws = 1'b0; cfg_we = 1'b0; load_req = 1'b0; sweep_en = 1'b0;
    cfg_beam = '0; cfg_ch = '0; cfg_delay = '0; sweep_last = '0; dwell_frames = '0; load_beam = '0;
    tick(); tick();
    reset = 1'b0;
    for (int b = 0; b < NUM_BEAMS; b++) for (int c = 0; c < NUM_CH; c++) mtbl[b][c] = 0;
    clear_q();
  endtask

  task automatic write_entry(input int b, input int c, input int d);
    cfg_we = 1'b1; cfg_beam = 3'(b); cfg_ch = 2'(c); cfg_delay = 3'(d);
    tick();
    cfg_we = 1'b0;
    if (c < NUM_CH) mtbl[b][c] = d;
  endtask

  task automatic fill_random();
    for (int b = 0; b < NUM_BEAMS; b++)
      for (int c = 0; c < NUM_CH; c++) write_entry(b, c, int'($urandom_range(0, 7)));
  endtask

  // Expected pulse stream: pair k carries channel k/IDX_W, bit IDX_W-1-(k%IDX_W) of the model table.
  function automatic logic [4*NP-1:0] exp_stream(input int b);
    logic [4*NP-1:0] s;
    int c, pos;
    s = '0;
    for (int k = 0; k < NP; k++) begin
      c = k / IDX_W;
      pos = IDX_W - 1 - (k % IDX_W);
      s[4*(NP-1-k) +: 4] = {3'(c), 1'((mtbl[b][c] >> pos) & 1)};
    end
    return s;
  endfunction

  function automatic logic [4*NP-1:0] got_stream(input int first);
    logic [4*NP-1:0] s;
    for (int k = 0; k < NP; k++)
      s[4*(NP-1-k) +: 4] = (first + k < pulse_q.size()) ? pulse_q[first + k] : 4'hF;
    return s;
  endfunction

  task automatic issue_load(input int b, output int ack_c, output int done_c);
    ack_c = -1; done_c = -1;
    load_beam = 3'(b); load_req = 1'b1;
    for (int i = 0; i < 40 && ack_c < 0; i++) begin
      @(negedge clk);
      if (load_ack === 1'b1) ack_c = cyc;
    end
    load_req = 1'b0;
    for (int i = 0; i < 40 && done_c < 0; i++) begin
      @(negedge clk);
      if (load_done === 1'b1) done_c = cyc;
    end
    tick();
  endtask

  task automatic ws_edge();
    ws = 1'b1; repeat (3) tick();
    ws = 1'b0; repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({busy, dly_clk, dly_data, load_ack, load_done} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000", {busy, dly_clk, dly_data, load_ack, load_done});
    end
    tests++;
    if (dly_sel !== 3'd0) begin fails++; $display("FAIL reset_sel: got %0d expected 0", dly_sel); end
    tests++;
    if (beam_idx !== 3'd0) begin fails++; $display("FAIL reset_beam: got %0d expected 0", beam_idx); end
  endtask

  task automatic test_manual();
    int ack_c, done_c, b, pbase;
    logic [4*NP-1:0] exp;
    logic [NP-1:0] bits;
    do_reset();
    pbase = proto_err;
    write_entry(2, 0, 5); write_entry(2, 1, 3); write_entry(2, 2, 6); write_entry(2, 3, 1);
    exp = exp_stream(2);
    clear_q();
    issue_load(2, ack_c, done_c);
    tests++;
    if (done_c - ack_c != 18) begin fails++; $display("FAIL manual_latency: got %0d expected 18", done_c - ack_c); end
    tests++;
    if (pulse_q.size() != NP) begin fails++; $display("FAIL manual_pulses: got %0d expected %0d", pulse_q.size(), NP); end
    for (int k = 0; k < NP; k++) bits[NP-1-k] = (k < pulse_q.size()) ? pulse_q[k][0] : 1'bx;
    tests++;
    if (bits !== 9'b101_011_110) begin fails++; $display("FAIL manual_bits: got %b expected 101011110", bits); end
    tests++;
    if (got_stream(0) !== exp) begin fails++; $display("FAIL manual_stream: got %h expected %h", got_stream(0), exp); end
    tests++;
    if (beam_idx !== 3'd2) begin fails++; $display("FAIL manual_beam: got %0d expected 2", beam_idx); end

    for (int it = 0; it < 6; it++) begin
      repeat (4) write_entry(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      b = int'($urandom_range(0, 7));
      exp = exp_stream(b);
      clear_q();
      issue_load(b, ack_c, done_c);
      tests++;
      if (done_c - ack_c != 18) begin fails++; $display("FAIL rand_latency: got %0d expected 18", done_c - ack_c); end
      tests++;
      if (got_stream(0) !== exp) begin fails++; $display("FAIL rand_stream: got %h expected %h", got_stream(0), exp); end
      tests++;
      if (int'(beam_idx) != b) begin fails++; $display("FAIL rand_beam: got %0d expected %0d", beam_idx, b); end
    end
    tests++;
    if (proto_err != pbase) begin fails++; $display("FAIL bus_protocol: got %0d errors expected 0", proto_err - pbase); end
  endtask

  task automatic test_mid_write();
    int hi, old, nd, ack_c, done_c;
    logic [4*NP-1:0] exp;
    do_reset();
    for (int c = 0; c < NUM_CH; c++) write_entry(4, c, int'($urandom_range(0, 7)));
    exp = exp_stream(4);
    old = mtbl[4][1];
    nd = (~old) & 7;
    clear_q();
    load_beam = 3'd4; load_req = 1'b1; hi = 0;
    for (int i = 0; i < 60 && hi < 2; i++) begin
      @(negedge clk);
      if (load_ack === 1'b1) load_req = 1'b0;
      if (dly_clk === 1'b1) hi++;
    end
    write_entry(4, 1, nd);
    for (int i = 0; i < 40 && done_beam_q.size() == 0; i++) @(negedge clk);
    tick();
    tests++;
    if (got_stream(0) !== exp) begin fails++; $display("FAIL midwrite_old: got %h expected %h", got_stream(0), exp); end
    exp = exp_stream(4);
    clear_q();
    issue_load(4, ack_c, done_c);
    tests++;
    if (got_stream(0) !== exp) begin fails++; $display("FAIL midwrite_new: got %h expected %h", got_stream(0), exp); end
  endtask

  task automatic test_sweep();
    int dwell, last, cur, cnt, edges, ack_c, done_c;
    int exp_beams [$];
    for (int s = 0; s < 3; s++) begin
      do_reset();
      fill_random();
      cur = 0; edges = 7; dwell = 2; last = 2;
      if (s != 0) begin
        dwell = int'($urandom_range(1, 3));
        last = int'($urandom_range(0, 7));
        edges = 8;
        cur = int'($urandom_range(0, 7));
        issue_load(cur, ack_c, done_c);
      end
      sweep_last = 3'(last); dwell_frames = 8'(dwell); sweep_en = 1'b1;
      cnt = 0; exp_beams.delete();
      clear_q();
      for (int e = 1; e <= edges; e++) begin
        ws_edge();
        repeat (30) tick();
        cnt++;
        if (cnt >= dwell) begin
          cnt = 0;
          cur = (cur >= last) ? 0 : cur + 1;
          exp_beams.push_back(cur);
        end
        tests++;
        if (done_beam_q.size() != exp_beams.size()) begin
          fails++; $display("FAIL sweep_count set %0d edge %0d: got %0d expected %0d", s, e, done_beam_q.size(), exp_beams.size());
        end
      end
      for (int i = 0; i < exp_beams.size() && i < done_beam_q.size(); i++) begin
        tests++;
        if (done_beam_q[i] != exp_beams[i]) begin
          fails++; $display("FAIL sweep_beam set %0d load %0d: got %0d expected %0d", s, i, done_beam_q[i], exp_beams[i]);
        end
      end
      if (exp_beams.size() > 0) begin
        tests++;
        if (got_stream(NP * (exp_beams.size() - 1)) !== exp_stream(cur)) begin
          fails++; $display("FAIL sweep_stream set %0d: got %h expected %h", s, got_stream(NP * (exp_beams.size() - 1)), exp_stream(cur));
        end
      end
      sweep_en = 1'b0;
      tick();
    end
  endtask

  task automatic test_collision();
    int m, nxt, acked;
    do_reset();
    fill_random();
    m = int'($urandom_range(0, 7));
    nxt = (m >= 7) ? 0 : m + 1;
    sweep_last = 3'd7; dwell_frames = 8'd1; sweep_en = 1'b1;
    tick();
    clear_q();
    ws = 1'b1; load_beam = 3'(m); load_req = 1'b1; acked = 0;
    for (int i = 0; i < 40 && acked == 0; i++) begin
      @(negedge clk);
      if (load_ack === 1'b1) acked = 1;
    end
    load_req = 1'b0;
    repeat (3) tick();
    ws = 1'b0;
    repeat (60) tick();
    tests++;
    if (done_beam_q.size() != 2) begin fails++; $display("FAIL collide_count: got %0d expected 2", done_beam_q.size()); end
    if (done_beam_q.size() >= 2 && start_cyc_q.size() >= 2) begin
      tests++;
      if (done_beam_q[0] != m) begin fails++; $display("FAIL collide_first: got %0d expected %0d", done_beam_q[0], m); end
      tests++;
      if (done_beam_q[1] != nxt) begin fails++; $display("FAIL collide_second: got %0d expected %0d", done_beam_q[1], nxt); end
      tests++;
      if (start_cyc_q[1] != done_cyc_q[0] + 2) begin
        fails++; $display("FAIL collide_start: got cycle %0d expected %0d", start_cyc_q[1], done_cyc_q[0] + 2);
      end
      tests++;
      if (got_stream(NP) !== exp_stream(nxt)) begin fails++; $display("FAIL collide_stream: got %h expected %h", got_stream(NP), exp_stream(nxt)); end
    end
    sweep_en = 1'b0;
    tick();
  endtask

  task automatic test_dwell_zero();
    int cur, last;
    do_reset();
    last = int'($urandom_range(1, 5));
    sweep_last = 3'(last); dwell_frames = 8'd0; sweep_en = 1'b1; cur = 0;
    for (int e = 1; e <= 5; e++) begin
      ws_edge();
      repeat (30) tick();
      cur = (cur >= last) ? 0 : cur + 1;
      tests++;
      if (done_beam_q.size() != e || done_beam_q[done_beam_q.size() - 1] != cur) begin
        fails++; $display("FAIL dwell0 edge %0d: got %0d loads last beam %0d expected %0d loads beam %0d",
                          e, done_beam_q.size(), beam_idx, e, cur);
      end
    end
    sweep_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    int hi, ack_c, done_c;
    do_reset();
    for (int c = 0; c < NUM_CH; c++) write_entry(1, c, int'($urandom_range(1, 7)));
    clear_q();
    load_beam = 3'd1; load_req = 1'b1; hi = 0;
    for (int i = 0; i < 60 && hi < 4; i++) begin
      @(negedge clk);
      if (load_ack === 1'b1) load_req = 1'b0;
      if (dly_clk === 1'b1) hi++;
    end
    load_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int b = 0; b < NUM_BEAMS; b++) for (int c = 0; c < NUM_CH; c++) mtbl[b][c] = 0;
    tests++;
    if (hi != 4 || busy !== 1'b0 || dly_clk !== 1'b0) begin
      fails++; $display("FAIL abort_state: got hi=%0d busy=%b dly_clk=%b expected hi=4 busy=0 dly_clk=0", hi, busy, dly_clk);
    end
    repeat (30) tick();
    tests++;
    if (done_beam_q.size() != 0) begin fails++; $display("FAIL abort_done: got %0d load_done expected 0", done_beam_q.size()); end
    clear_q();
    issue_load(1, ack_c, done_c);
    tests++;
    if (got_stream(0) !== exp_stream(1)) begin fails++; $display("FAIL abort_table: got %h expected %h", got_stream(0), exp_stream(1)); end
    tests++;
    if (beam_idx !== 3'd1) begin fails++; $display("FAIL abort_beam: got %0d expected 1", beam_idx); end
  endtask

  initial begin
    reset = 1'b1; ws = 1'b0; cfg_we = 1'b0; load_req = 1'b0; sweep_en = 1'b0;
    test_reset();
    test_manual();
    test_mid_write();
    test_sweep();
    test_collision();
    test_dwell_zero();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
